// File: rtl/rr_reg_arbiter.sv
// Round-robin arbiter feeding a single registered output stage over valid/ready.
// Optional burst locking is enabled by defining RR_ARB_LOCK_EN.
module rr_reg_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REQ    = 4,
    parameter int ID_WIDTH   = $clog2(NUM_REQ)
) (
    input  logic                          clk_i,
    input  logic                          rstn_i,
    input  logic [NUM_REQ-1:0]            req_valid_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
    input  logic [NUM_REQ-1:0]            req_last_i,
    output logic [NUM_REQ-1:0]            req_ready_o,
    output logic                          out_valid_o,
    output logic [DATA_WIDTH-1:0]         out_data_o,
    output logic [ID_WIDTH-1:0]           out_id_o,
    input  logic                          out_ready_i
);

    logic                  out_valid_p1;
    logic [DATA_WIDTH-1:0] out_data_p1;
    logic [ID_WIDTH-1:0]   out_id_p1;
    logic [ID_WIDTH-1:0]   ptr_p1;
    logic [ID_WIDTH-1:0]   ptr_nxt;

    logic                  load;
    logic                  rr_valid;
    logic [ID_WIDTH-1:0]   rr_winner;
    logic [ID_WIDTH:0]     rr_sum;
    logic [ID_WIDTH-1:0]   rr_idx;
    logic                  grant_valid;
    logic [ID_WIDTH-1:0]   winner;
    logic [ID_WIDTH-1:0]   winner_inc;
    logic [DATA_WIDTH-1:0] win_data;
    logic                  xfer;

    assign load = !out_valid_p1 || out_ready_i;

    // Rotating priority search beginning at ptr, wrapping modulo NUM_REQ.
    always_comb begin
        rr_valid  = 1'b0;
        rr_winner = '0;
        rr_sum    = '0;
        rr_idx    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            rr_sum = {1'b0, ptr_p1} + (ID_WIDTH+1)'(i);
            if (rr_sum >= (ID_WIDTH+1)'(NUM_REQ)) begin
                rr_sum = rr_sum - (ID_WIDTH+1)'(NUM_REQ);
            end
            rr_idx = rr_sum[ID_WIDTH-1:0];
            if (!rr_valid && req_valid_i[rr_idx]) begin
                rr_valid  = 1'b1;
                rr_winner = rr_idx;
            end
        end
    end

    assign winner_inc = (winner == ID_WIDTH'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
    assign xfer       = load && grant_valid;

    always_comb begin
        win_data = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (winner == ID_WIDTH'(k)) begin
                win_data = req_data_i[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_comb begin
        req_ready_o = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            req_ready_o[k] = rstn_i && xfer && (winner == ID_WIDTH'(k));
        end
    end

`ifdef RR_ARB_LOCK_EN
    typedef enum logic {
        ARB  = 1'b0,
        LOCK = 1'b1
    } state_t;

    state_t              state_p1;
    state_t              state_nxt;
    logic [ID_WIDTH-1:0] lock_id_p1;
    logic [ID_WIDTH-1:0] lock_id_nxt;
    logic                win_last;

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state_p1   <= ARB;
            lock_id_p1 <= '0;
        end else begin
            state_p1   <= state_nxt;
            lock_id_p1 <= lock_id_nxt;
        end
    end

    // While locked only the owner of the burst may be granted, even if idle.
    always_comb begin
        winner      = rr_winner;
        grant_valid = rr_valid;
        if (state_p1 == LOCK) begin
            winner      = lock_id_p1;
            grant_valid = req_valid_i[lock_id_p1];
        end
    end

    assign win_last = req_last_i[winner];

    always_comb begin
        state_nxt   = state_p1;
        lock_id_nxt = lock_id_p1;
        ptr_nxt     = ptr_p1;
        case (state_p1)
            ARB: begin
                if (xfer && !win_last) begin
                    state_nxt   = LOCK;
                    lock_id_nxt = winner;
                end
            end
            LOCK: begin
                if (xfer && win_last) begin
                    state_nxt = ARB;
                end
            end
            default: state_nxt = ARB;
        endcase
        // Pointer only advances once a burst has finished.
        if (xfer && win_last) begin
            ptr_nxt = winner_inc;
        end
    end
`else
    logic unused_last;

    assign unused_last = ^req_last_i;
    assign winner      = rr_winner;
    assign grant_valid = rr_valid;
    assign ptr_nxt     = xfer ? winner_inc : ptr_p1;
`endif

    // Output register stage
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            out_valid_p1 <= 1'b0;
            out_data_p1  <= '0;
            out_id_p1    <= '0;
            ptr_p1       <= '0;
        end else if (load) begin
            out_valid_p1 <= xfer;
            ptr_p1       <= ptr_nxt;
            if (xfer) begin
                out_data_p1 <= win_data;
                out_id_p1   <= winner;
            end
        end
    end

    assign out_valid_o = out_valid_p1;
    assign out_data_o  = out_data_p1;
    assign out_id_o    = out_id_p1;

endmodule

// File: tb/tb_rr_reg_arbiter.sv
// Directed self-checking bench for rr_reg_arbiter (lock checks active when RR_ARB_LOCK_EN is defined).
module tb_rr_reg_arbiter;

    localparam int DATA_WIDTH = 32;
    localparam int NUM_REQ    = 4;
    localparam int ID_WIDTH   = 2;

    logic                          clk;
    logic                          rstn;
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            req_last;
    logic [NUM_REQ-1:0]            req_ready;
    logic                          out_valid;
    logic [DATA_WIDTH-1:0]         out_data;
    logic [ID_WIDTH-1:0]           out_id;
    logic                          out_ready;

    int n_checks = 0;
    int n_errors = 0;

    rr_reg_arbiter #(
        .DATA_WIDTH(DATA_WIDTH),
        .NUM_REQ   (NUM_REQ),
        .ID_WIDTH  (ID_WIDTH)
    ) dut (
        .clk_i      (clk),
        .rstn_i     (rstn),
        .req_valid_i(req_valid),
        .req_data_i (req_data),
        .req_last_i (req_last),
        .req_ready_o(req_ready),
        .out_valid_o(out_valid),
        .out_data_o (out_data),
        .out_id_o   (out_id),
        .out_ready_i(out_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill_data();
        for (int k = 0; k < NUM_REQ; k++) begin
            req_data[k*DATA_WIDTH +: DATA_WIDTH] = 32'hAAAA0000 | 32'(k);
        end
    endtask

    task automatic check_out(input string tag, input logic v, input logic [31:0] d, input logic [1:0] id);
        check({tag, "_valid"}, 64'(out_valid), 64'(v));
        check({tag, "_data"},  64'(out_data),  64'(d));
        check({tag, "_id"},    64'(out_id),    64'(id));
    endtask

    initial begin
        clk       = 1'b0;
        rstn      = 1'b0;
        req_valid = 4'b1111;
        req_last  = 4'b1111;
        out_ready = 1'b1;
        fill_data();

        // Reset: ready forced low, outputs cleared
        #1;
        check("rst_ready", 64'(req_ready), 64'(4'b0000));
        tick();
        tick();
        check("rst_ready_late", 64'(req_ready), 64'(4'b0000));
        check_out("rst", 1'b0, 32'h0, 2'd0);

        // Single requester 2
        rstn      = 1'b1;
        req_valid = 4'b0100;
        req_data[2*DATA_WIDTH +: DATA_WIDTH] = 32'h0000_0022;
        #1;
        check("t1_ready", 64'(req_ready), 64'(4'b0100));
        tick();
        check_out("t1", 1'b1, 32'h0000_0022, 2'd2);

        // Reset drops the held word and ptr; then all four valid rotate 0,1,2,3,0,1
        rstn      = 1'b0;
        req_valid = 4'b0000;
        tick();
        check_out("t2_rst", 1'b0, 32'h0, 2'd0);
        rstn      = 1'b1;
        req_valid = 4'b1111;
        fill_data();
        for (int i = 0; i < 6; i++) begin
            #1;
            check("t2_ready", 64'(req_ready), 64'(4'b0001 << (i % 4)));
            tick();
            check_out("t2", 1'b1, 32'hAAAA0000 | 32'(i % 4), 2'(i % 4));
        end

        // Stall with id 1 held; requesters 0 and 3 waiting, ptr = 2
        req_valid = 4'b1001;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("t3_stall_ready", 64'(req_ready), 64'(4'b0000));
            tick();
            check_out("t3_stall", 1'b1, 32'hAAAA0001, 2'd1);
        end
        out_ready = 1'b1;
        #1;
        check("t3_release_ready", 64'(req_ready), 64'(4'b1000));
        tick();
        check_out("t3_release", 1'b1, 32'hAAAA0003, 2'd3);

        // Back-to-back words from requester 0, no bubble
        req_valid = 4'b0001;
        for (int i = 0; i < 4; i++) begin
            req_data[0 +: DATA_WIDTH] = 32'h100 + 32'(i);
            #1;
            check("t4_ready", 64'(req_ready), 64'(4'b0001));
            tick();
            check_out("t4", 1'b1, 32'h100 + 32'(i), 2'd0);
        end

        // Drain with nobody valid: valid drops, data/id hold
        req_valid = 4'b0000;
        #1;
        check("t4_idle_ready", 64'(req_ready), 64'(4'b0000));
        tick();
        check_out("t4_drain", 1'b0, 32'h103, 2'd0);

        // Reset during a stall with ptr = 3; afterwards requester 0 wins first
        req_valid = 4'b0100;
        req_data[2*DATA_WIDTH +: DATA_WIDTH] = 32'h55;
        tick();
        out_ready = 1'b0;
        req_valid = 4'b0000;
        tick();
        check_out("t6_held", 1'b1, 32'h55, 2'd2);
        rstn = 1'b0;
        tick();
        check_out("t6_rst", 1'b0, 32'h0, 2'd0);
        rstn      = 1'b1;
        out_ready = 1'b1;
        req_valid = 4'b1111;
        fill_data();
        #1;
        check("t6_ready", 64'(req_ready), 64'(4'b0001));
        tick();
        check_out("t6_first", 1'b1, 32'hAAAA0000, 2'd0);

`ifdef RR_ARB_LOCK_EN
        // Burst locking
        rstn      = 1'b0;
        req_valid = 4'b0000;
        req_last  = 4'b1111;
        tick();
        rstn      = 1'b1;
        req_valid = 4'b0001;
        tick();
        check("lk_pre_id", 64'(out_id), 64'(2'd0));
        req_valid = 4'b0011;
        req_last  = 4'b1101;
        for (int b = 0; b < 3; b++) begin
            if (b == 2) req_last = 4'b1111;
            #1;
            check("lk_burst_ready", 64'(req_ready), 64'(4'b0010));
            tick();
            check_out("lk_burst", 1'b1, 32'hAAAA0001, 2'd1);
        end
        #1;
        check("lk_after_ready", 64'(req_ready), 64'(4'b0001));
        tick();
        check("lk_after_id", 64'(out_id), 64'(2'd0));

        // Owner goes idle mid-burst: nobody else granted
        req_last = 4'b1101;
        #1;
        check("lk_mid_ready", 64'(req_ready), 64'(4'b0010));
        tick();
        req_valid = 4'b0001;
        #1;
        check("lk_idle_ready", 64'(req_ready), 64'(4'b0000));
        tick();
        check("lk_idle_valid", 64'(out_valid), 64'(1'b0));

        // Reset while locked and holding a word
        req_valid = 4'b0010;
        tick();
        check_out("lk_hold", 1'b1, 32'hAAAA0001, 2'd1);
        out_ready = 1'b0;
        rstn      = 1'b0;
        tick();
        check_out("lk_rst", 1'b0, 32'h0, 2'd0);
        rstn      = 1'b1;
        out_ready = 1'b1;
        req_valid = 4'b0011;
        req_last  = 4'b1111;
        #1;
        check("lk_unlock_ready", 64'(req_ready), 64'(4'b0001));
        tick();
        check("lk_unlock_id", 64'(out_id), 64'(2'd0));
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/rr_reg_arbiter.md
# rr_reg_arbiter

Round-robin arbiter that shares one registered output stage among `NUM_REQ` requesters using valid/ready handshakes. Each cycle it selects one valid requester, captures that requester's data into the output register, and presents it downstream with the winner's index. It sits between several producer blocks and a single consumer of register-stage data. It is the sharing and sequencing front end for the team's flip-flop datapath stage.

## Interface
Parameters:
- `DATA_WIDTH`, 32: payload width per requester.
- `NUM_REQ`, 4: number of requesters; must be at least 2.
- `ID_WIDTH`, `$clog2(NUM_REQ)`: width of the winner index.

Ports:
- `clk_i`  in  1  single clock; all state updates on rising edge.
- `rstn_i`  in  1  reset, synchronous, active-low.
- `req_valid_i`  in  NUM_REQ  per-requester valid.
- `req_data_i`  in  NUM_REQ*DATA_WIDTH  flattened payloads; requester k occupies bits `[k*DATA_WIDTH +: DATA_WIDTH]`.
- `req_last_i`  in  NUM_REQ  per-requester end-of-burst flag; used only under `RR_ARB_LOCK_EN`.
- `req_ready_o`  out  NUM_REQ  per-requester accept; one-hot or zero.
- `out_valid_o`  out  1  output register holds valid data.
- `out_data_o`  out  DATA_WIDTH  registered payload.
- `out_id_o`  out  ID_WIDTH  index of the requester whose data is in the register.
- `out_ready_i`  in  1  downstream accept.

## Operation
- Load enable: `load = !out_valid_o || out_ready_i`. This gives a single-entry pipeline register with full throughput.
- Grant selection (combinational):
  - Search `req_valid_i` starting at `ptr` and wrap modulo NUM_REQ.
  - The first valid index wins.
  - If no requester is valid, there is no grant.
- `req_ready_o[g] = load && grant_valid && (g == winner)`. All other bits are 0.
- `req_ready_o` depends on `req_valid_i` combinationally. Requesters must not make valid depend on ready.
- Transfer from requester g occurs when `req_valid_i[g] && req_ready_o[g]`. On that edge:
  - `out_data_o` captures the data of requester g.
  - `out_id_o` captures g.
  - `out_valid_o` is set to 1.
  - `ptr` becomes `(g+1) mod NUM_REQ`, wrapping from NUM_REQ-1 to 0.
- If `load` is 1 and no transfer occurs, `out_valid_o` goes to 0. `out_data_o` and `out_id_o` hold their previous values.
- If `load` is 0 (stall), all output-side registers and `ptr` hold.
- State machine, active only with `RR_ARB_LOCK_EN`:
  - Two states, ARB and LOCK, with a register `lock_id`.
  - ARB → LOCK: on a transfer with `req_last_i[g] = 0`; `lock_id` is set to g.
  - LOCK → ARB: on a transfer from `lock_id` with last = 1.
  - In LOCK only `lock_id` can be granted, even if it is idle and others are valid.
  - `ptr` updates only on the transfer that returns the block to ARB.
- Reset (`rstn_i = 0` at a rising edge) sets:
  - `out_valid_o = 0`, `out_data_o = 0`, `out_id_o = 0`
  - `ptr = 0`, state = ARB, `lock_id = 0`
- While `rstn_i = 0`, `req_ready_o` is forced to 0.
- Reset mid-burst or mid-stall drops the held word and any lock.

## Timing
- Latency is 1 cycle: data accepted at edge N appears on `out_data_o` immediately after edge N. `out_valid_o` is high from N until the consumer's accepting edge.
- Throughput is 1 word per cycle when `out_ready_i` stays 1.
- When downstream drains and a new requester loads on the same edge, `out_valid_o` stays 1 with no bubble.
- With `out_valid_o = 1` and `out_ready_i = 0`, `out_data_o` and `out_id_o` are stable and `req_ready_o = 0`.
- With all NUM_REQ requesters valid continuously, each is granted exactly once every NUM_REQ transfers.

## Configuration
- `RR_ARB_LOCK_EN` defined:
  - Burst locking per the ARB/LOCK state machine.
  - `req_last_i` is honoured.
- Undefined:
  - No lock logic; arbitration occurs on every transfer.
  - `req_last_i` is ignored (port remains, treated as all-ones).

## Test plan
1. Reset, then only requester 2 valid with data 32'h0000_0022 and `out_ready_i = 1` → `req_ready_o = 4'b0100`; next cycle `out_valid_o = 1`, `out_data_o = 32'h0000_0022`, `out_id_o = 2`.
2. All four valid continuously, data 32'hAAAA000k for requester k, `out_ready_i = 1` → `out_id_o` sequence is 0,1,2,3,0,1, showing wrap, and each data word matches its id.
3. Requester 1 loaded, `out_ready_i = 0` for 3 cycles while requesters 0 and 3 are valid → output holds 1 / 32'hAAAA0001 and `req_ready_o = 0`. On release, next `out_id_o = 3` (ptr = 2).
4. Requester 0 valid with `out_ready_i = 1` every cycle → no bubble: `out_valid_o` stays 1 and a new word appears each cycle.
5. `RR_ARB_LOCK_EN`: requester 1 sends 3 beats with last = 0,0,1 while requester 0 is always valid → ids are 1,1,1, then 0.
   - If requester 1 drops valid mid-burst, `out_valid_o` drains to 0 and requester 0 is not granted.
6. Assert `rstn_i = 0` for one edge while `out_valid_o = 1` and locked → `out_valid_o`, `out_data_o` and `out_id_o` become 0 and the lock is cleared. After release, requester 0 wins first.
